temp_entry_ctrl: RTL

- Sequences operator temperature entry from the PS/2 receiver into the 5-bit temperature register.
- Filters make/break/extended prefixes and accumulates up to two decimal digits.
- Validates the value against MAX_TEMP on Enter, then issues a one-cycle load with the value.
- Sits between the keyboard receiver (rx_listo, codigo_tecla) and the temperature register/display path.

---
 rtl/temp_entry_pkg.sv | 61 ++++++
 rtl/ps2_key_filter.sv | 77 +++++++
 rtl/temp_entry_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/temp_entry_pkg.sv
// Shared definitions for operator temperature entry.
// Holds the PS/2 set-2 scan codes, the entry FSM state encoding and the
// scan-code-to-digit decoder.
package temp_entry_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned TEMP_W = 5;
  localparam int unsigned ACC_W  = 7;

  localparam logic [CODE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
  localparam logic [CODE_W-1:0] SC_CLEAR = 8'h66;

  localparam logic [CODE_W-1:0] SC_D0 = 8'h45;
  localparam logic [CODE_W-1:0] SC_D1 = 8'h16;
  localparam logic [CODE_W-1:0] SC_D2 = 8'h1E;
  localparam logic [CODE_W-1:0] SC_D3 = 8'h26;
  localparam logic [CODE_W-1:0] SC_D4 = 8'h25;
  localparam logic [CODE_W-1:0] SC_D5 = 8'h2E;
  localparam logic [CODE_W-1:0] SC_D6 = 8'h36;
  localparam logic [CODE_W-1:0] SC_D7 = 8'h3D;
  localparam logic [CODE_W-1:0] SC_D8 = 8'h3E;
  localparam logic [CODE_W-1:0] SC_D9 = 8'h46;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_D1     = 2'd1,
    ST_D2     = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  // Map a scan byte to a decimal digit; extended keys are never digits.
  function automatic digit_t scan_to_digit(input logic [CODE_W-1:0] code,
                                           input logic              ext);
    digit_t r;
    r.valid = 1'b1;
    r.value = 4'd0;
    case (code)
      SC_D0:   r.value = 4'd0;
      SC_D1:   r.value = 4'd1;
      SC_D2:   r.value = 4'd2;
      SC_D3:   r.value = 4'd3;
      SC_D4:   r.value = 4'd4;
      SC_D5:   r.value = 4'd5;
      SC_D6:   r.value = 4'd6;
      SC_D7:   r.value = 4'd7;
      SC_D8:   r.value = 4'd8;
      SC_D9:   r.value = 4'd9;
      default: r.valid = 1'b0;
    endcase
    if (ext) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_filter.sv
// PS/2 prefix filter: strips break (F0) sequences and tags extended (E0) keys.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous clear of prefix state (entry mode off)
//   rx_listo        receiver strobe, codigo_tecla valid
//   codigo_tecla    raw scan byte
//   key_valid       one-cycle strobe, one cycle after the accepted rx_listo
//   key_code        make code of the accepted key
//   key_ext         key was preceded by E0
module ps2_key_filter
  import temp_entry_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              rx_listo,
  input  logic [CODE_W-1:0] codigo_tecla,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_ext
);

  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_ext_q, key_ext_d;

  // Prefix tracking and key acceptance.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    if (flush) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_listo) begin
      if (codigo_tecla == SC_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        // Released key: drop it, and any E0 that preceded the F0.
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (codigo_tecla == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        key_valid_d = 1'b1;
        key_code_d  = codigo_tecla;
        key_ext_d   = ext_q;
        ext_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;

endmodule

// File: rtl/temp_entry_ctrl.sv
// Operator temperature entry sequencer: collects up to two decimal digits
// from the PS/2 receiver, range-checks on Enter and issues a one-cycle load.
// Ports:
//   clk, rst        clock, async active-low reset
//   inicio_progra   entry mode enable (level)
//   rx_listo        receiver strobe; codigo_tecla valid
//   codigo_tecla    PS/2 set-2 scan byte
//   enable_rx       receiver enable (registered inicio_progra)
//   carga           one-cycle load strobe to the temperature register
//   temp_out        committed temperature, held between commits
//   digitos         digits currently entered (0..2)
//   error           sticky entry error
//   ocupado         partial entry in progress
module temp_entry_ctrl
  import temp_entry_pkg::*;
#(
  parameter int unsigned MAX_TEMP    = 31,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio_progra,
  input  logic              rx_listo,
  input  logic [CODE_W-1:0] codigo_tecla,
  output logic              enable_rx,
  output logic              carga,
  output logic [TEMP_W-1:0] temp_out,
  output logic [1:0]        digitos,
  output logic              error,
  output logic              ocupado
);

  localparam int unsigned TMR_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(MAX_TEMP);

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ext;

  ps2_key_filter u_filter (
    .clk          (clk),
    .rst_n        (rst),
    .flush        (~inicio_progra),
    .rx_listo     (rx_listo),
    .codigo_tecla (codigo_tecla),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext)
  );

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pend_q, pend_d;
  logic [CODE_W-1:0] pend_code_q, pend_code_d;
  logic              pend_ext_q, pend_ext_d;
  logic              enable_rx_q, enable_rx_d;
  logic              carga_q, carga_d;
  logic [TEMP_W-1:0] temp_out_q, temp_out_d;
  logic [1:0]        digitos_q, digitos_d;
  logic              error_q, error_d;
  logic              ocupado_q, ocupado_d;

  logic              kv;
  logic [CODE_W-1:0] kcode;
  logic              kext;
  digit_t            dig;
  logic              is_enter;
  logic              is_clear;
  logic              in_entry;
  logic              expired;

  // Key seen by the FSM: a key parked during COMMIT takes priority in IDLE.
  always_comb begin
    kv    = 1'b0;
    kcode = key_code;
    kext  = key_ext;
    if (pend_q && state_q == ST_IDLE) begin
      kv    = 1'b1;
      kcode = pend_code_q;
      kext  = pend_ext_q;
    end else if (key_valid && state_q != ST_COMMIT) begin
      kv = 1'b1;
    end
  end

  assign dig      = scan_to_digit(kcode, kext);
  assign is_enter = (kcode == SC_ENTER);
  assign is_clear = (kcode == SC_CLEAR);
  assign in_entry = (state_q == ST_D1) || (state_q == ST_D2);
  assign expired  = in_entry && (timer_q == TMR_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    error_d     = error_q;
    temp_out_d  = temp_out_q;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    pend_ext_d  = pend_ext_q;
    timer_d     = '0;
    enable_rx_d = inicio_progra;

    if (kv) begin
      timer_d = '0;
    end else if (in_entry) begin
      timer_d = timer_q + TMR_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (kv && dig.valid) begin
          acc_d   = ACC_W'(dig.value);
          error_d = 1'b0;
          state_d = ST_D1;
        end
      end
      ST_D1, ST_D2: begin
        if (kv) begin
          if (dig.valid) begin
            if (state_q == ST_D1) begin
              acc_d   = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(dig.value);
              state_d = ST_D2;
            end else begin
              // Third digit: reject it but keep the two already entered.
              error_d = 1'b1;
            end
          end else if (is_enter) begin
            if (acc_q <= ACC_MAX) begin
              temp_out_d = acc_q[TEMP_W-1:0];
              error_d    = 1'b0;
              state_d    = ST_COMMIT;
            end else begin
              error_d = 1'b1;
              acc_d   = '0;
              state_d = ST_IDLE;
            end
          end else if (is_clear) begin
            acc_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (expired) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        acc_d       = '0;
        state_d     = ST_IDLE;
        pend_d      = key_valid;
        pend_code_d = key_code;
        pend_ext_d  = key_ext;
      end
      default: begin
        acc_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Leaving entry mode aborts everything except the committed value.
    if (!inicio_progra) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      error_d    = 1'b0;
      pend_d     = 1'b0;
      timer_d    = '0;
      temp_out_d = temp_out_q;
    end

    carga_d   = (state_d == ST_COMMIT);
    ocupado_d = (state_d == ST_D1) || (state_d == ST_D2);
    case (state_d)
      ST_D1:   digitos_d = 2'd1;
      ST_D2:   digitos_d = 2'd2;
      default: digitos_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      pend_ext_q  <= 1'b0;
      enable_rx_q <= 1'b0;
      carga_q     <= 1'b0;
      temp_out_q  <= '0;
      digitos_q   <= 2'd0;
      error_q     <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      pend_ext_q  <= pend_ext_d;
      enable_rx_q <= enable_rx_d;
      carga_q     <= carga_d;
      temp_out_q  <= temp_out_d;
      digitos_q   <= digitos_d;
      error_q     <= error_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign enable_rx = enable_rx_q;
  assign carga     = carga_q;
  assign temp_out  = temp_out_q;
  assign digitos   = digitos_q;
  assign error     = error_q;
  assign ocupado   = ocupado_q;

endmodule
